// File: rtl/quick_spi_slave.sv
// SPI peripheral oversampled in clk: one RX word in, one held TX word out per frame.
// rx_valid 3 clk after final sample edge; tx_ready low while the TX holding register is full.
module quick_spi_slave #(
    parameter int RX_DATA_WIDTH = 16,
    parameter int TX_DATA_WIDTH = 8,
    parameter bit CPOL          = 1'b0,
    parameter bit CPHA          = 1'b0,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     ss_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe,
    input  logic [TX_DATA_WIDTH-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [RX_DATA_WIDTH-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic                     frame_error,
    output logic                     tx_underrun
);

    localparam int RXCW = $clog2(RX_DATA_WIDTH + 1);
    localparam int TXCW = $clog2(TX_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_DESELECT,
        IDLE,
        SHIFT
    } state_t;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                   state_q, state_d;
    logic [TX_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                     hold_vld_q, hold_vld_d;
    logic [TX_DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [TXCW-1:0]          tx_cnt_q, tx_cnt_d;
    logic                     miso_q, miso_d;
    logic [RX_DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [RXCW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [RX_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     frame_error_q, frame_error_d;
    logic                     tx_underrun_q, tx_underrun_d;

    logic                     sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                     sample_edge, shift_edge;
    logic [TX_DATA_WIDTH-1:0] load_word;
    logic [RX_DATA_WIDTH-1:0] rx_shifted;

    function automatic logic tx_head(input logic [TX_DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[TX_DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [TX_DATA_WIDTH-1:0] tx_tail(input logic [TX_DATA_WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // ss_n sync resets low so the block only arms after really seeing the pin high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ss_meta_q   <= ss_n;
            ss_sync_q   <= ss_meta_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign rx_shifted  = MSB_FIRST ? {rx_sr_q[RX_DATA_WIDTH-2:0], mosi_sync_q}
                                   : {mosi_sync_q, rx_sr_q[RX_DATA_WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        tx_sr_d       = tx_sr_q;
        tx_cnt_d      = tx_cnt_q;
        miso_d        = miso_q;
        rx_sr_d       = rx_sr_q;
        rx_cnt_d      = rx_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        tx_underrun_d = 1'b0;
        load_word     = hold_vld_q ? hold_q : '0;

        case (state_q)
            WAIT_DESELECT: begin
                if (ss_sync_q) state_d = IDLE;
            end
            IDLE: begin
                if (!ss_sync_q) begin
                    state_d       = SHIFT;
                    rx_sr_d       = '0;
                    rx_cnt_d      = '0;
                    hold_vld_d    = 1'b0;
                    tx_underrun_d = !hold_vld_q;
                    if (!CPHA) begin
                        miso_d   = tx_head(load_word);
                        tx_sr_d  = tx_tail(load_word);
                        tx_cnt_d = TXCW'(1);
                    end else begin
                        miso_d   = 1'b0;
                        tx_sr_d  = load_word;
                        tx_cnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                // Deselect wins over any sclk edge seen in the same cycle.
                if (ss_sync_q) begin
                    state_d       = IDLE;
                    miso_d        = 1'b0;
                    frame_error_d = (rx_cnt_q < RXCW'(RX_DATA_WIDTH));
                end else begin
                    if (sample_edge && (rx_cnt_q < RXCW'(RX_DATA_WIDTH))) begin
                        rx_sr_d  = rx_shifted;
                        rx_cnt_d = rx_cnt_q + RXCW'(1);
                        if (rx_cnt_q == RXCW'(RX_DATA_WIDTH - 1)) begin
                            rx_data_d  = rx_shifted;
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (tx_cnt_q < TXCW'(TX_DATA_WIDTH)) begin
                            miso_d   = tx_head(tx_sr_q);
                            tx_sr_d  = tx_tail(tx_sr_q);
                            tx_cnt_d = tx_cnt_q + TXCW'(1);
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = WAIT_DESELECT;
        endcase

        // A word accepted on the frame-start cycle lands after consumption, for the next frame.
        if (tx_valid && !hold_vld_q) begin
            hold_d     = tx_data;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_DESELECT;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            tx_sr_q       <= '0;
            tx_cnt_q      <= '0;
            miso_q        <= 1'b0;
            rx_sr_q       <= '0;
            rx_cnt_q      <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            tx_sr_q       <= tx_sr_d;
            tx_cnt_q      <= tx_cnt_d;
            miso_q        <= miso_d;
            rx_sr_q       <= rx_sr_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == SHIFT);
    assign busy        = (state_q == SHIFT);
    assign tx_ready    = !hold_vld_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign tx_underrun = tx_underrun_q;

endmodule
